uart_rx_buffered: RTL and testbench
===================================

Name: uart_rx_buffered

Overview:
- 8N1 UART receiver with an output FIFO. It takes host-to-board serial data, such as digit images and commands, and presents bytes on a valid/ready stream to the recognition datapath.
- It is the receiving end of the host link. The MicroBlaze UART drives uart_txd toward the host; this block is its counterpart on the uart_rxd pin.
- Features: 16x oversampling, majority-vote sampling, framing-error and overrun detection.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD, 115200, line rate.
- OVERSAMPLE, 16, sample ticks per bit. Fixed at 16; other values are unsupported.
- FIFO_DEPTH, 16, output buffer entries. Must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial input; idle high; asynchronous to clk.
- m_data  out  8  received byte at the FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid & m_ready.
- frame_err  out  1  sticky: a stop bit was sampled low.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- err_clr  in  1  one-cycle pulse clears frame_err and overrun.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset: asynchronous assert, synchronous deassert handled upstream.
  - Outputs on reset: m_valid=0, m_data=0, frame_err=0, overrun=0, fifo_count=0.
  - FSM goes to IDLE; synchronizer flops are set to 1 (idle line).
  - Reset mid-frame discards the partial byte; FIFO contents are lost.
- Input synchronizer: 2-FF on uart_rxd → rxd_s. All logic uses rxd_s only.
- Tick generator:
  - DIV = (CLK_FREQ_HZ + BAUD*8) / (BAUD*16), rounded; 54 at defaults.
  - Counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - Free-running; it is not resynchronized to the start edge. Edge uncertainty of 1/16 bit is acceptable.
- FSM (states IDLE, START, DATA, STOP), sample counter scnt 0..15, bit index bidx 0..7:
  - IDLE: on a tick with rxd_s=0 → START, scnt=0.
  - START: count ticks. At scnt=7 (mid-bit), if rxd_s=1 it is a glitch → IDLE, with no error and no byte. Otherwise continue; at scnt=15 → DATA, bidx=0.
  - DATA: sample rxd_s at scnt=7,8,9; bit value = majority of the three. At scnt=15, shift the bit in LSB-first.
    - If bidx=7 → STOP; else bidx++.
  - STOP: majority sample at 7/8/9. At scnt=9 → IDLE immediately; leaving early allows back-to-back frames with clock skew up to ±3%.
    - Stop=1: push byte into the FIFO.
    - Stop=0: set frame_err and discard the byte; no push.
    - After a framing error, IDLE rearms only once rxd_s has been seen high on a tick, so a break condition does not generate repeated frames.
- FIFO: synchronous, FIFO_DEPTH entries; pointers of width $clog2(DEPTH)+1, with wrap detected by the MSB.
  - First-word-fall-through: m_data is valid in the same cycle m_valid=1.
  - Push is accepted the cycle after the stop sample. m_valid rises 1 cycle after the push (registered count).
  - Pop on m_valid & m_ready.
  - Full: a push while full with no simultaneous pop drops the new byte and sets overrun. Existing data is preserved.
  - Full with a simultaneous pop: both occur; count unchanged; no overrun.
  - Empty with a simultaneous push: m_ready is ignored (m_valid=0); the byte is stored.
- Errors: frame_err and overrun stay set until err_clr.
  - If err_clr coincides with a new error event, the set wins.
- Latency: stop-bit mid-sample to m_valid = 2 clk cycles.

Decomposition:
- Package uart_rx_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  - localparam for OVERSAMPLE=16, the mid-sample indices 7/8/9, and DATA_BITS=8;
  - function calc_div(clk_hz, baud).
- One sub-module: rx_byte_fifo, parameterized by DEPTH and WIDTH. The FSM, tick generator and synchronizer stay in the top.

Test Plan:
- 0x55 at 115200 baud, clk 100 MHz, m_ready=1 → single m_valid pulse, m_data=0x55, no error flags.
- 0xA3, 0x00, 0xFF back-to-back with no idle gap, m_ready=1 → three bytes in order; fifo_count never exceeds 1.
- Low glitch on uart_rxd lasting 3 µs (< half bit) → no byte, no frame_err, FSM back in IDLE.
- Frame 0x3C with stop bit forced low, then a normal 0x3C → first frame: frame_err=1, no push; second frame: byte 0x3C; err_clr pulse → frame_err=0.
- m_ready=0, send 17 bytes 0x00..0x10 → fifo_count=16, overrun=1. Then drain with m_ready=1 → bytes 0x00..0x0F; 0x10 is lost.
- Reset pulse at bit 4 of a frame of 0xC7, followed by a complete 0x5A → no partial byte, m_valid=0 right after reset, then exactly one byte 0x5A.
- Optional: clock skew ±2.5% between the bench UART and the DUT → all bytes correct.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the buffered 8N1 UART receiver.
// The baud divider is computed here so the top level and any host-side model agree on it.
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_A   = 7;
    localparam int SAMPLE_B   = 8;
    localparam int SAMPLE_C   = 9;
    localparam int DATA_BITS  = 8;

    // Rounded clk / (16 * baud), never below 1 so the tick counter always advances.
    function automatic int calc_div(input longint clk_hz, input longint baud);
        longint d;
        d = (clk_hz + baud * 8) / (baud * 16);
        if (d < 1) d = 1;
        return int'(d);
    endfunction

endpackage

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO between the UART framer and the stream consumer.
// Reports a dropped push (full, no simultaneous pop) so the caller can flag an overrun.
module rx_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full, empty, do_pop, do_push;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = !empty && pop_ready;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign count     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver: 2-FF synchronizer, free-running 16x tick, majority-vote framer,
// and an output FIFO presenting bytes on a valid/ready stream with sticky error flags.
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rxd,
    output logic [7:0]                    m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [3:0] SCNT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_A     = 4'(SAMPLE_A);
    localparam logic [3:0] MID_B     = 4'(SAMPLE_B);
    localparam logic [3:0] MID_C     = 4'(SAMPLE_C);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic sync1_q, rxd_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            rxd_s_q <= sync1_q;
        end
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick;

    always_comb begin
        tick      = (div_cnt_q == DIV_W'(DIV - 1));
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
    end

    uart_rx_state_t       state_q, state_d;
    logic [3:0]           scnt_q, scnt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [1:0]           samp_q, samp_d;
    logic                 bit_q, bit_d;
    logic                 armed_q, armed_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 vote, frame_set, fifo_drop;

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bidx_d    = bidx_q;
        shreg_d   = shreg_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        armed_d   = armed_q;
        push_d    = 1'b0;
        frame_set = 1'b0;
        vote      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s_q) | (samp_q[1] & rxd_s_q);

        if (tick) begin
            case (state_q)
                IDLE: begin
                    // After a framing error the line must be seen idle before a new start is honoured.
                    if (!armed_q) begin
                        armed_d = rxd_s_q;
                    end else if (!rxd_s_q) begin
                        state_d = START;
                        scnt_d  = '0;
                    end
                end
                START: begin
                    if (scnt_q == MID_A && rxd_s_q) begin
                        state_d = IDLE;
                    end else if (scnt_q == SCNT_LAST) begin
                        state_d = DATA;
                        scnt_d  = '0;
                        bidx_d  = '0;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
                DATA: begin
                    if (scnt_q == MID_A) samp_d[0] = rxd_s_q;
                    if (scnt_q == MID_B) samp_d[1] = rxd_s_q;
                    if (scnt_q == MID_C) bit_d     = vote;
                    if (scnt_q == SCNT_LAST) begin
                        scnt_d  = '0;
                        shreg_d = {bit_q, shreg_q[DATA_BITS-1:1]};
                        if (bidx_q == LAST_BIT) state_d = STOP;
                        else                    bidx_d  = bidx_q + 3'd1;
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
                STOP: begin
                    if (scnt_q == MID_A) samp_d[0] = rxd_s_q;
                    if (scnt_q == MID_B) samp_d[1] = rxd_s_q;
                    // Leave at the last vote sample so a slightly fast sender's next start is not missed.
                    if (scnt_q == MID_C) begin
                        state_d = IDLE;
                        if (vote) begin
                            push_d = 1'b1;
                        end else begin
                            frame_set = 1'b1;
                            armed_d   = 1'b0;
                        end
                    end else begin
                        scnt_d = scnt_q + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        frame_err_d = frame_set | (frame_err_q & ~err_clr);
        overrun_d   = fifo_drop | (overrun_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q   <= '0;
            state_q     <= IDLE;
            scnt_q      <= '0;
            bidx_q      <= '0;
            shreg_q     <= '0;
            samp_q      <= '0;
            bit_q       <= 1'b0;
            armed_q     <= 1'b1;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            bidx_q      <= bidx_d;
            shreg_q     <= shreg_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            armed_q     <= armed_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_q),
        .push_data (shreg_q),
        .pop_ready (m_ready),
        .out_data  (m_data),
        .out_valid (m_valid),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed and randomized frames driven onto uart_rxd; received bytes are compared
// against a queue model of an ideal 8N1 receiver with a bounded buffer.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    localparam int CLK_HZ = 100_000_000;
    localparam int BAUD   = 1_562_500;
    localparam int DEPTH  = 16;
    localparam int BIT_NS = 1_000_000_000 / BAUD;

    logic                     clk;
    logic                     rst_n;
    logic                     uart_rxd;
    logic [7:0]               m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     frame_err;
    logic                     overrun;
    logic                     err_clr;
    logic [$clog2(DEPTH):0]   fifo_count;

    uart_rx_buffered #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD),
        .OVERSAMPLE  (16),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rxd   (uart_rxd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         max_count = 0;
    int         rises     = 0;
    logic       prev_valid = 1'b0;
    logic       ovf_exp;
    logic [7:0] b;
    logic [7:0] partial_b;
    int         n;

    // Consumer side: record every accepted byte, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) got_q.push_back(m_data);
            if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
            if (m_valid && !prev_valid) rises++;
        end
        prev_valid = m_valid;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input int bit_ns, input logic stop_bit);
        uart_rxd = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = data[i];
            #(bit_ns);
        end
        uart_rxd = stop_bit;
        #(bit_ns);
        uart_rxd = 1'b1;
    endtask

    task automatic idle_bits(input int nbits);
        #(nbits * BIT_NS);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 m_ready = v;
    endtask

    task automatic clear_rx();
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        max_count = 0;
        rises     = 0;
    endtask

    task automatic pulse_err_clr();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        m_ready  = 1'b0;
        err_clr  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_m_valid",    32'(m_valid),    0);
        check("rst_m_data",     32'(m_data),     0);
        check("rst_frame_err",  32'(frame_err),  0);
        check("rst_overrun",    32'(overrun),    0);
        check("rst_fifo_count", 32'(fifo_count), 0);
        rst_n = 1'b1;
        idle_bits(1);

        // Single byte
        set_ready(1'b1);
        clear_rx();
        exp_q.push_back(8'h55);
        send_frame(8'h55, BIT_NS, 1'b1);
        idle_bits(2);
        compare_rx("byte55");
        check("byte55_valid_pulses", rises, 1);
        check("byte55_frame_err", 32'(frame_err), 0);
        check("byte55_overrun",   32'(overrun),   0);

        // Back-to-back frames with no idle gap
        clear_rx();
        exp_q = '{8'hA3, 8'h00, 8'hFF};
        send_frame(8'hA3, BIT_NS, 1'b1);
        send_frame(8'h00, BIT_NS, 1'b1);
        send_frame(8'hFF, BIT_NS, 1'b1);
        idle_bits(2);
        compare_rx("b2b");
        check("b2b_max_count", max_count, 1);

        // Short low glitch must be rejected; receiver then still decodes a frame
        clear_rx();
        uart_rxd = 1'b0;
        #(BIT_NS * 35 / 100);
        uart_rxd = 1'b1;
        idle_bits(3);
        check("glitch_bytes",     got_q.size(), 0);
        check("glitch_frame_err", 32'(frame_err), 0);
        check("glitch_count",     32'(fifo_count), 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, BIT_NS, 1'b1);
        idle_bits(2);
        compare_rx("post_glitch");

        // Framing error followed by a short break, then a good frame
        clear_rx();
        send_frame(8'h3C, BIT_NS, 1'b0);
        uart_rxd = 1'b0;
        #(2 * BIT_NS);
        uart_rxd = 1'b1;
        idle_bits(2);
        check("ferr_flag",  32'(frame_err), 1);
        check("ferr_bytes", got_q.size(), 0);
        check("ferr_count", 32'(fifo_count), 0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, BIT_NS, 1'b1);
        idle_bits(2);
        compare_rx("ferr_next");
        check("ferr_sticky", 32'(frame_err), 1);
        pulse_err_clr();
        check("ferr_cleared", 32'(frame_err), 0);

        // Overrun: 17 bytes into a 16-entry buffer with no consumer
        set_ready(1'b0);
        clear_rx();
        ovf_exp = 1'b0;
        for (int k = 0; k < 17; k++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(k));
            else                      ovf_exp = 1'b1;
            send_frame(8'(k), BIT_NS, 1'b1);
        end
        idle_bits(2);
        check("ovf_count",   32'(fifo_count), exp_q.size());
        check("ovf_flag",    32'(overrun),    32'(ovf_exp));
        check("ovf_valid",   32'(m_valid),    1);
        check("ovf_head",    32'(m_data),     32'(exp_q[0]));
        set_ready(1'b1);
        idle_bits(1);
        compare_rx("ovf_drain");
        check("ovf_drained", 32'(fifo_count), 0);
        check("ovf_sticky",  32'(overrun),    1);
        pulse_err_clr();
        check("ovf_cleared", 32'(overrun),    0);

        // Random bytes with random idle gaps, consumer always ready
        clear_rx();
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, BIT_NS, 1'b1);
            #($urandom_range(0, 2) * BIT_NS);
        end
        idle_bits(2);
        compare_rx("rand");

        // Random burst length against a stalled consumer
        set_ready(1'b0);
        clear_rx();
        n       = $urandom_range(10, 20);
        ovf_exp = 1'b0;
        for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else                      ovf_exp = 1'b1;
            send_frame(b, BIT_NS, 1'b1);
        end
        idle_bits(2);
        check("burst_count",   32'(fifo_count), exp_q.size());
        check("burst_overrun", 32'(overrun),    32'(ovf_exp));
        set_ready(1'b1);
        idle_bits(1);
        compare_rx("burst_drain");
        pulse_err_clr();

        // Sender clock skewed by +2.5% and -2.5%
        clear_rx();
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, BIT_NS * 1025 / 1000, 1'b1);
        end
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(b, BIT_NS * 975 / 1000, 1'b1);
        end
        idle_bits(2);
        compare_rx("skew");
        check("skew_frame_err", 32'(frame_err), 0);

        // Reset in the middle of a frame discards it and the buffered byte
        set_ready(1'b0);
        clear_rx();
        send_frame(8'h11, BIT_NS, 1'b1);
        idle_bits(2);
        check("prerst_count", 32'(fifo_count), 1);
        partial_b = 8'hC7;
        uart_rxd  = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = partial_b[i];
            #(BIT_NS);
        end
        uart_rxd = partial_b[4];
        #(BIT_NS / 2);
        rst_n    = 1'b0;
        uart_rxd = 1'b1;
        #100;
        check("midrst_valid", 32'(m_valid),    0);
        check("midrst_data",  32'(m_data),     0);
        check("midrst_count", 32'(fifo_count), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_bits(2);
        check("postrst_valid", 32'(m_valid), 0);
        set_ready(1'b1);
        clear_rx();
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, BIT_NS, 1'b1);
        idle_bits(2);
        compare_rx("postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
